// File: rtl/subtractor_seq.sv
// Multi-cycle chunked ripple-borrow subtractor: d = a - b - bi, K bits per clock,
// with valid/ready handshakes on the operand and result sides.
module subtractor_seq #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bo,
  output logic         ovf
);

  localparam int C  = N / K;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic            r_borrow;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_d;
  logic            r_bo;
  logic            r_ovf;

  logic [K-1:0]    w_a_chunk;
  logic [K-1:0]    w_b_chunk;
  logic [K:0]      w_diff;
  logic            w_t;
  logic [K-1:0]    w_r;
  logic            w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: registers take <= so every flop samples pre-edge values, independent of block order.
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Chunk currently addressed by the counter; the counter never exceeds C-1.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < C; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_chunk = r_a[i*K +: K];
        w_b_chunk = r_b[i*K +: K];
      end
    end
  end

  assign w_diff = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{K{1'b0}}, r_borrow};
  assign w_t    = w_diff[K];
  assign w_r    = w_diff[K-1:0];
  assign w_last = (r_cnt == CW'(C - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_bo     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bi;
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          for (int i = 0; i < C; i++) begin
            if (r_cnt == CW'(i)) r_d[i*K +: K] <= w_r;
          end
          r_borrow <= w_t;
          if (w_last) begin
            r_bo  <= w_t;
            // Overflow only when operand signs differ and the result sign departs from a's.
            r_ovf <= (r_a[N-1] != r_b[N-1]) && (w_r[K-1] != r_a[N-1]);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign d   = r_d;
  assign bo  = r_bo;
  assign ovf = r_ovf;

endmodule
